// File: rtl/fifo_write_arbiter.sv
`timescale 1ns/1ps
// fifo_write_arbiter
//   Round-robin arbiter sharing one async-FIFO write port among N requesters
//   in the write clock domain. A granted requester keeps the port for up to
//   MAX_BURST accepted words, then the port is re-arbitrated with the
//   previous owner at lowest priority. wfull stalls the burst without
//   losing the grant.
//
// Ports:
//   wclk, wrst   write clock, asynchronous active-high reset
//   req[N]       per-requester request, held with its data until gnt
//   wdata_in     requester i data on bits [i*DSIZE +: DSIZE]
//   gnt[N]       one-hot pulse per accepted word
//   wfull        FIFO full flag
//   winc, wdata  FIFO write strobe and data (data is 0 when winc is 0)
//   busy         a requester owns the port
//   owner        current or last owner index
//   stall_cnt    (FIFO_ARB_STATS_EN only) saturating count of cycles in
//                which the owner wanted to write but the FIFO was full
//
// Build option: define FIFO_ARB_STATS_EN to add the stall_cnt port.

module fifo_write_arbiter #(
  parameter int N         = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4,
  parameter int IDW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic               wclk,
  input  logic               wrst,
  input  logic [N-1:0]       req,
  input  logic [N*DSIZE-1:0] wdata_in,
  output logic [N-1:0]       gnt,
  input  logic               wfull,
  output logic               winc,
  output logic [DSIZE-1:0]   wdata,
  output logic               busy,
  output logic [IDW-1:0]     owner
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [IDW-1:0]  rr;
  logic [BW-1:0]   beat_cnt;
  logic            req_own;
  logic [DSIZE-1:0] data_own;

  // First set request scanning upward from ptr+1 with wrap; ptr itself is
  // examined last, which gives the previous owner the lowest priority.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r,
                                             input logic [IDW-1:0] ptr);
    logic [IDW-1:0] idx;
    logic           found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Outputs are decoded from state so a reset between clock edges removes
  // any pending write at once.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    req_own  = 1'b0;
    data_own = '0;
    for (int i = 0; i < N; i++) begin
      if (owner == IDW'(i)) begin
        req_own  = req[i];
        data_own = wdata_in[i*DSIZE +: DSIZE];
      end
    end
    busy  = (state == GRANT);
    winc  = busy && req_own && !wfull;
    wdata = winc ? data_own : '0;
    gnt   = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = winc && (owner == IDW'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state    <= IDLE;
      owner    <= '0;
      rr       <= IDW'(N - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            owner    <= rr_pick(req, rr);
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (!req_own || (winc && beat_cnt == LAST_BEAT)) begin
            // Release or burst end: re-arbitrate this cycle from owner+1.
            rr       <= owner;
            beat_cnt <= '0;
            if (|req) begin
              owner <= rr_pick(req, owner);
            end else begin
              state <= IDLE;
            end
          end else if (winc) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          // wfull with req held: owner and beat_cnt simply hold.
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      stall_cnt <= '0;
    end else if (busy && req_own && wfull && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // No stall statistics in this build.
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
`timescale 1ns/1ps
module tb_fifo_write_arbiter;

  localparam int N         = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;
  localparam int IDW       = 2;

  logic               wclk = 1'b0;
  logic               wrst = 1'b0;
  logic [N-1:0]       req = '0;
  logic [N*DSIZE-1:0] wdata_in = '0;
  logic [N-1:0]       gnt;
  logic               wfull = 1'b0;
  logic               winc;
  logic [DSIZE-1:0]   wdata;
  logic               busy;
  logic [IDW-1:0]     owner;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]        stall_cnt;
`endif

  fifo_write_arbiter #(.N(N), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .req      (req),
    .wdata_in (wdata_in),
    .gnt      (gnt),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .busy     (busy),
    .owner    (owner)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Producer models: remaining words and next data per requester.
  int         left   [N];
  logic [7:0] data_q [N];

  // Write log and last sampled outputs.
  logic [N-1:0] log_gnt [$];
  logic [7:0]   log_data[$];
  int           log_cyc [$];
  logic [N-1:0] s_gnt;
  logic         s_winc, s_busy;
  logic [IDW-1:0] s_owner;
  logic [7:0]   s_wdata;

  // One clock: sample at the falling edge, update producers just after the
  // rising edge on which a granted word was accepted.
  task automatic tick();
    logic [N-1:0] g;
    @(negedge wclk);
    cyc++;
    s_gnt = gnt; s_winc = winc; s_busy = busy; s_owner = owner; s_wdata = wdata;
    if (winc) begin
      log_gnt.push_back(gnt);
      log_data.push_back(wdata);
      log_cyc.push_back(cyc);
    end
    g = gnt;
    @(posedge wclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (g[i] && left[i] > 0) begin
        data_q[i] = data_q[i] + 8'd1;
        left[i]   = left[i] - 1;
        if (left[i] == 0) req[i] = 1'b0;
        wdata_in[i*DSIZE +: DSIZE] = data_q[i];
      end
    end
  endtask

  task automatic load(input int i, input logic [7:0] base, input int n);
    data_q[i] = base;
    left[i]   = n;
    wdata_in[i*DSIZE +: DSIZE] = base;
    req[i]    = 1'b1;
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    wfull = 1'b0;
    req = '0;
    wdata_in = '0;
    for (int i = 0; i < N; i++) begin left[i] = 0; data_q[i] = '0; end
    @(posedge wclk); #1;
    @(posedge wclk); #1;
    wrst = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int budget);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      if (req == '0 && !busy) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: busy=%0b req=%b required idle within %0d cycles", name, busy, req, budget);
    end
  endtask

  task automatic wait_writes(input string name, input int target, input int budget);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      if (log_data.size() >= target) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s write wait: got %0d writes required %0d", name, log_data.size(), target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({s_gnt, s_winc, s_busy, s_owner, s_wdata} !== {4'b0, 1'b0, 1'b0, 2'd0, 8'h00}) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: gnt=%b winc=%b busy=%b owner=%0d wdata=%h required all 0",
                 k, s_gnt, s_winc, s_busy, s_owner, s_wdata);
      end
    end
`ifdef FIFO_ARB_STATS_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt);
    end
`endif
  endtask

  task automatic test_single_burst();
    int start, c0;
    do_reset();
    start = log_data.size();
    c0 = cyc;
    load(2, 8'hA0, 8);
    run_until_done("single_burst", 40);
    checks++;
    if (log_data.size() - start !== 8) begin
      failures++;
      $display("FAIL single_burst count: got %0d writes required 8", log_data.size() - start);
    end else begin
      checks++;
      if (log_cyc[start] !== c0 + 2) begin
        failures++;
        $display("FAIL single_burst latency: first write cycle %0d required %0d", log_cyc[start], c0 + 2);
      end
      for (int w = 0; w < 8; w++) begin
        checks++;
        if (log_gnt[start+w] !== 4'b0100 || log_data[start+w] !== 8'hA0 + 8'(w)) begin
          failures++;
          $display("FAIL single_burst word %0d: gnt=%b data=%h required gnt=0100 data=%h",
                   w, log_gnt[start+w], log_data[start+w], 8'hA0 + 8'(w));
        end
      end
      checks++;
      if (log_cyc[start+7] > c0 + 10) begin
        failures++;
        $display("FAIL single_burst span: last write cycle %0d required at most %0d", log_cyc[start+7], c0 + 10);
      end
    end
  endtask

  task automatic test_round_robin();
    int start, eo;
    logic [7:0] ed;
    do_reset();
    start = log_data.size();
    load(0, 8'h10, 8);
    load(1, 8'h20, 4);
    load(2, 8'h30, 4);
    load(3, 8'h40, 4);
    run_until_done("round_robin", 80);
    checks++;
    if (log_data.size() - start !== 20) begin
      failures++;
      $display("FAIL round_robin count: got %0d writes required 20", log_data.size() - start);
    end else begin
      for (int w = 0; w < 20; w++) begin
        eo = (w / 4) % 4;
        if (eo == 0) ed = 8'h10 + 8'((w < 16) ? (w % 4) : (4 + w % 4));
        else         ed = 8'(8'h10 * (eo + 1) + (w % 4));
        checks++;
        if (log_gnt[start+w] !== 4'(1 << eo) || log_data[start+w] !== ed) begin
          failures++;
          $display("FAIL round_robin word %0d: gnt=%b data=%h required gnt=%b data=%h",
                   w, log_gnt[start+w], log_data[start+w], 4'(1 << eo), ed);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    int start;
    do_reset();
    start = log_data.size();
    load(1, 8'h50, 4);
    wait_writes("back_pressure", start + 2, 10);
    wfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (s_winc !== 1'b0 || s_gnt !== 4'b0 || s_owner !== 2'd1 || s_busy !== 1'b1) begin
        failures++;
        $display("FAIL back_pressure stall %0d: winc=%b gnt=%b owner=%0d busy=%b required 0,0000,1,1",
                 k, s_winc, s_gnt, s_owner, s_busy);
      end
    end
`ifdef FIFO_ARB_STATS_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      failures++;
      $display("FAIL back_pressure stall_cnt: got %0d required 5", stall_cnt);
    end
`endif
    wfull = 1'b0;
    run_until_done("back_pressure", 20);
    checks++;
    if (log_data.size() - start !== 4) begin
      failures++;
      $display("FAIL back_pressure count: got %0d writes required 4", log_data.size() - start);
    end else begin
      for (int w = 2; w < 4; w++) begin
        checks++;
        if (log_gnt[start+w] !== 4'b0010 || log_data[start+w] !== 8'h50 + 8'(w)) begin
          failures++;
          $display("FAIL back_pressure word %0d: gnt=%b data=%h required gnt=0010 data=%h",
                   w, log_gnt[start+w], log_data[start+w], 8'h50 + 8'(w));
        end
      end
    end
`ifdef FIFO_ARB_STATS_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      failures++;
      $display("FAIL back_pressure stall_cnt_hold: got %0d required 5", stall_cnt);
    end
`endif
  endtask

  task automatic test_early_release();
    int start;
    do_reset();
    start = log_data.size();
    load(0, 8'h60, 2);
    load(3, 8'h70, 4);
    wait_writes("early_release", start + 2, 10);
    tick();
    checks++;
    if (s_winc !== 1'b0 || s_owner !== 2'd0) begin
      failures++;
      $display("FAIL early_release drop: winc=%b owner=%0d required winc=0 owner=0", s_winc, s_owner);
    end
    tick();
    checks++;
    if (s_owner !== 2'd3 || s_winc !== 1'b1 || s_wdata !== 8'h70) begin
      failures++;
      $display("FAIL early_release switch: owner=%0d winc=%b wdata=%h required owner=3 winc=1 wdata=70",
               s_owner, s_winc, s_wdata);
    end
    run_until_done("early_release", 20);
    checks++;
    if (log_data.size() - start !== 6) begin
      failures++;
      $display("FAIL early_release count: got %0d writes required 6", log_data.size() - start);
    end else begin
      for (int w = 0; w < 6; w++) begin
        logic [N-1:0] eg;
        logic [7:0]   ed;
        eg = (w < 2) ? 4'b0001 : 4'b1000;
        ed = (w < 2) ? 8'h60 + 8'(w) : 8'h70 + 8'(w - 2);
        checks++;
        if (log_gnt[start+w] !== eg || log_data[start+w] !== ed) begin
          failures++;
          $display("FAIL early_release word %0d: gnt=%b data=%h required gnt=%b data=%h",
                   w, log_gnt[start+w], log_data[start+w], eg, ed);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int start, c0;
    do_reset();
    start = log_data.size();
    load(2, 8'h80, 8);
    wait_writes("async_reset", start + 2, 10);
    checks++;
    if (winc !== 1'b1 || owner !== 2'd2) begin
      failures++;
      $display("FAIL async_reset pre: winc=%b owner=%0d required winc=1 owner=2", winc, owner);
    end
    #2;
    wrst = 1'b1;
    #1;
    checks++;
    if (winc !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0 || owner !== 2'd0 || wdata !== 8'h00) begin
      failures++;
      $display("FAIL async_reset immediate: winc=%b gnt=%b busy=%b owner=%0d wdata=%h required all 0",
               winc, gnt, busy, owner, wdata);
    end
    req = '0;
    for (int i = 0; i < N; i++) left[i] = 0;
    @(posedge wclk); #1;
    wrst = 1'b0;
    start = log_data.size();
    c0 = cyc;
    load(1, 8'h90, 2);
    load(2, 8'hA0, 2);
    run_until_done("async_reset", 20);
    checks++;
    if (log_data.size() - start !== 4) begin
      failures++;
      $display("FAIL async_reset count: got %0d writes required 4", log_data.size() - start);
    end else begin
      checks++;
      if (log_cyc[start] !== c0 + 2) begin
        failures++;
        $display("FAIL async_reset latency: first write cycle %0d required %0d", log_cyc[start], c0 + 2);
      end
      for (int w = 0; w < 4; w++) begin
        logic [N-1:0] eg;
        logic [7:0]   ed;
        eg = (w < 2) ? 4'b0010 : 4'b0100;
        ed = (w < 2) ? 8'h90 + 8'(w) : 8'hA0 + 8'(w - 2);
        checks++;
        if (log_gnt[start+w] !== eg || log_data[start+w] !== ed) begin
          failures++;
          $display("FAIL async_reset word %0d: gnt=%b data=%h required gnt=%b data=%h",
                   w, log_gnt[start+w], log_data[start+w], eg, ed);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin left[i] = 0; data_q[i] = '0; end
    test_reset();
    test_single_burst();
    test_round_robin();
    test_back_pressure();
    test_early_release();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
